wb_writeback_unit: RTL and testbench
====================================

// Module: wb_writeback_unit
// PURPOSE
//  WB-stage writer for the ID register-file write port (Rd_addr/Rd_wr_data/Rd_wr_en).
//  Takes retiring MEM-stage results, waits for data-memory load data and aligns/extends it.
//  Drives one registered write per retired instruction and stalls upstream while a load is pending.
//  Also counts retired instructions (instret) and flags load faults.
// PARAMETERS
//  DATA_WIDTH   32  register/data width
//  ADDR_WIDTH   5   register address width
//  LOAD_TIMEOUT 16  max WAIT_LOAD cycles without Dmem_rvalid before fault (>=2)
//  CNT_WIDTH    32  width of Instret counter
// PORTS
//  Clk             in   1           clock
//  Reset_n         in   1           synchronous, active-low reset
//  MEM_valid       in   1           MEM stage presents a retiring instruction
//  MEM_rd_addr     in   ADDR_WIDTH  destination register
//  MEM_rd_wr_en    in   1           instruction writes rd
//  MEM_is_load     in   1           instruction is a load
//  MEM_load_funct3 in   3           load type (RV32I funct3)
//  MEM_byte_offset in   2           load address[1:0]
//  MEM_alu_result  in   DATA_WIDTH  non-load result
//  Dmem_rvalid     in   1           load data valid this cycle
//  Dmem_rdata      in   DATA_WIDTH  load word (aligned 32-bit word)
//  WB_stall        out  1           hold MEM inputs stable (combinational)
//  Rd_addr         out  ADDR_WIDTH  regfile write address (registered)
//  Rd_wr_data      out  DATA_WIDTH  regfile write data (registered)
//  Rd_wr_en        out  1           regfile write strobe, 1-cycle pulse (registered)
//  Load_fault      out  1           1-cycle pulse: illegal/misaligned load or timeout
//  Instret         out  CNT_WIDTH   retired-instruction count
// BEHAVIOUR
//  Reset (Reset_n=0 at Clk edge): state=IDLE, tcnt=0, all registered outputs 0, Instret=0;
//   WB_stall forced 0 while Reset_n=0. Reset mid-WAIT_LOAD drops the pending load, no write.
//  FSM IDLE:
//   - MEM_valid & !is_load: next cycle Rd_addr=rd, Rd_wr_data=alu_result,
//     Rd_wr_en=MEM_rd_wr_en & (rd!=0); Instret+1. Latency 1, no stall.
//   - MEM_valid & is_load & illegal funct3 (011/110/111) or misaligned (LH/LHU offset[0]=1,
//     LW offset!=0): next cycle Load_fault=1, no write, no Instret increment, stay IDLE.
//   - MEM_valid & legal load & Dmem_rvalid: next cycle write aligned data (as ALU op), stay IDLE.
//   - MEM_valid & legal load & !Dmem_rvalid: latch rd/wr_en/funct3/offset, tcnt=0, ->WAIT_LOAD;
//     WB_stall=1 this cycle.
//   - Dmem_rvalid with no load accepted: ignored.
//  FSM WAIT_LOAD (MEM inputs ignored):
//   - Dmem_rvalid: next cycle write aligned data from latched fields, Instret+1, ->IDLE.
//   - else tcnt==LOAD_TIMEOUT-1: next cycle Load_fault=1, no write, ->IDLE.
//   - else tcnt+1, stay.
//   - WB_stall = !Dmem_rvalid & (tcnt!=LOAD_TIMEOUT-1).
//  Alignment (b=byte at offset*8, h=half at offset[1]*16):
//   000 LB sext(b); 001 LH sext(h); 010 LW word; 100 LBU zext(b); 101 LHU zext(h).
//  Rd_wr_en and Load_fault are low in every cycle without an event; Rd_addr/Rd_wr_data hold last value.
//  rd=x0: retires (Instret+1) with Rd_wr_en=0. Instret wraps 2^CNT_WIDTH-1 -> 0.
//  Never Rd_wr_en and Load_fault in the same cycle.
// TESTING
//  1 ALU: MEM_valid, rd=5, wr_en=1, alu=0xDEADBEEF -> next cycle Rd_wr_en=1, Rd_addr=5, data=0xDEADBEEF, Instret=1.
//  2 Align, rvalid same cycle, rdata=0x80FF1234: LB off3->0xFFFFFF80; LBU off3->0x00000080;
//    LH off2->0xFFFF80FF; LHU off2->0x000080FF; LW off0->0x80FF1234.
//  3 LW rd=7, rvalid 3 cycles after accept -> WB_stall high cycles 0-2, low cycle 3; Rd_wr_en=1 cycle 4.
//  4 LW, no rvalid -> WB_stall high 16 cycles (0-15), low cycle 16; Load_fault=1 cycle 17; no write; IDLE.
//  5 rd=0 wr_en=1 and LH off1 -> no Rd_wr_en; Instret+1 for first only; Load_fault pulse for second.
//  6 Reset_n=0 during WAIT_LOAD, then rvalid -> state IDLE, WB_stall=0, no write, Instret=0.

Source files
------------

// File: rtl/wb_writeback_unit.sv
// Write-back stage: retires MEM results into the register file, waits on and aligns
// load data, stalls upstream while a load is outstanding, and counts retired instructions.
module wb_writeback_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  MEM_valid,
  input  logic [ADDR_WIDTH-1:0] MEM_rd_addr,
  input  logic                  MEM_rd_wr_en,
  input  logic                  MEM_is_load,
  input  logic [2:0]            MEM_load_funct3,
  input  logic [1:0]            MEM_byte_offset,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result,
  input  logic                  Dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] Dmem_rdata,
  output logic                  WB_stall,
  output logic [ADDR_WIDTH-1:0] Rd_addr,
  output logic [DATA_WIDTH-1:0] Rd_wr_data,
  output logic                  Rd_wr_en,
  output logic                  Load_fault,
  output logic [CNT_WIDTH-1:0]  Instret
);

  localparam int TCNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(LOAD_TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

  state_t                  state;
  logic [TCNT_W-1:0]       tcnt;
  logic [ADDR_WIDTH-1:0]   rd_addr_p1;
  logic                    rd_wr_en_p1;
  logic [2:0]              funct3_p1;
  logic [1:0]              offset_p1;
  logic                    load_ok;

  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: load_legal = 1'b1;
      3'b001, 3'b101: load_legal = ~off[0];
      3'b010:         load_legal = (off == 2'b00);
      default:        load_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_align(input logic [2:0] f3,
                                                       input logic [1:0] off,
                                                       input logic [DATA_WIDTH-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_align = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  load_align = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b100:  load_align = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  load_align = {{(DATA_WIDTH-16){1'b0}}, h};
      default: load_align = word;
    endcase
  endfunction

  assign load_ok = load_legal(MEM_load_funct3, MEM_byte_offset);

  always_comb begin
    WB_stall = 1'b0;
    if (Reset_n) begin
      if (state == IDLE)
        WB_stall = MEM_valid & MEM_is_load & load_ok & ~Dmem_rvalid;
      else
        WB_stall = ~Dmem_rvalid & (tcnt != TCNT_LAST);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      rd_addr_p1  <= '0;
      rd_wr_en_p1 <= 1'b0;
      funct3_p1   <= '0;
      offset_p1   <= '0;
      Rd_addr     <= '0;
      Rd_wr_data  <= '0;
      Rd_wr_en    <= 1'b0;
      Load_fault  <= 1'b0;
      Instret     <= '0;
    end else begin
      Rd_wr_en   <= 1'b0;
      Load_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (MEM_valid) begin
            if (!MEM_is_load) begin
              Rd_addr    <= MEM_rd_addr;
              Rd_wr_data <= MEM_alu_result;
              Rd_wr_en   <= MEM_rd_wr_en & (MEM_rd_addr != '0);
              Instret    <= Instret + CNT_WIDTH'(1);
            end else if (!load_ok) begin
              Load_fault <= 1'b1;
            end else if (Dmem_rvalid) begin
              Rd_addr    <= MEM_rd_addr;
              Rd_wr_data <= load_align(MEM_load_funct3, MEM_byte_offset, Dmem_rdata);
              Rd_wr_en   <= MEM_rd_wr_en & (MEM_rd_addr != '0);
              Instret    <= Instret + CNT_WIDTH'(1);
            end else begin
              rd_addr_p1  <= MEM_rd_addr;
              rd_wr_en_p1 <= MEM_rd_wr_en;
              funct3_p1   <= MEM_load_funct3;
              offset_p1   <= MEM_byte_offset;
              tcnt        <= '0;
              state       <= WAIT_LOAD;
            end
          end
        end
        // Outstanding load: MEM inputs are held by the stall and ignored here
        WAIT_LOAD: begin
          if (Dmem_rvalid) begin
            Rd_addr    <= rd_addr_p1;
            Rd_wr_data <= load_align(funct3_p1, offset_p1, Dmem_rdata);
            Rd_wr_en   <= rd_wr_en_p1 & (rd_addr_p1 != '0);
            Instret    <= Instret + CNT_WIDTH'(1);
            state      <= IDLE;
          end else if (tcnt == TCNT_LAST) begin
            Load_fault <= 1'b1;
            state      <= IDLE;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed bench for wb_writeback_unit: vector table for single-cycle retirements
// plus hand-written sequences for wait, timeout, reset and counter wrap.
module tb_wb_writeback_unit;

  localparam int CW = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        MEM_valid;
  logic [4:0]  MEM_rd_addr;
  logic        MEM_rd_wr_en;
  logic        MEM_is_load;
  logic [2:0]  MEM_load_funct3;
  logic [1:0]  MEM_byte_offset;
  logic [31:0] MEM_alu_result;
  logic        Dmem_rvalid;
  logic [31:0] Dmem_rdata;
  logic        WB_stall;
  logic [4:0]  Rd_addr;
  logic [31:0] Rd_wr_data;
  logic        Rd_wr_en;
  logic        Load_fault;
  logic [CW-1:0] Instret;

  int n_cmp = 0;
  int n_fail = 0;
  logic [CW-1:0] exp_instret = '0;

  wb_writeback_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LOAD_TIMEOUT(16), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .MEM_valid(MEM_valid), .MEM_rd_addr(MEM_rd_addr), .MEM_rd_wr_en(MEM_rd_wr_en),
    .MEM_is_load(MEM_is_load), .MEM_load_funct3(MEM_load_funct3),
    .MEM_byte_offset(MEM_byte_offset), .MEM_alu_result(MEM_alu_result),
    .Dmem_rvalid(Dmem_rvalid), .Dmem_rdata(Dmem_rdata),
    .WB_stall(WB_stall), .Rd_addr(Rd_addr), .Rd_wr_data(Rd_wr_data),
    .Rd_wr_en(Rd_wr_en), .Load_fault(Load_fault), .Instret(Instret)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        wr_en;
    logic        is_load;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] alu;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_en;
    logic [31:0] exp_data;
    logic        exp_fault;
    logic        inc;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                       input logic [2:0] f3, input logic [1:0] off, input logic [31:0] alu,
                       input logic rv, input logic [31:0] rdat);
    MEM_valid = v; MEM_rd_addr = rd; MEM_rd_wr_en = we; MEM_is_load = ld;
    MEM_load_funct3 = f3; MEM_byte_offset = off; MEM_alu_result = alu;
    Dmem_rvalid = rv; Dmem_rdata = rdat;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 2'd0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    localparam logic [31:0] R = 32'h80FF1234;
    vecs[0]  = '{1'b1, 5'd5,  1'b1, 1'b0, 3'b000, 2'd0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 5'd1,  1'b1, 1'b1, 3'b000, 2'd3, 32'h0, 1'b1, R, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 5'd2,  1'b1, 1'b1, 3'b100, 2'd3, 32'h0, 1'b1, R, 1'b1, 32'h00000080, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 5'd3,  1'b1, 1'b1, 3'b001, 2'd2, 32'h0, 1'b1, R, 1'b1, 32'hFFFF80FF, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 5'd4,  1'b1, 1'b1, 3'b101, 2'd2, 32'h0, 1'b1, R, 1'b1, 32'h000080FF, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 5'd6,  1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 1'b1, R, 1'b1, 32'h80FF1234, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 5'd8,  1'b1, 1'b1, 3'b000, 2'd1, 32'h0, 1'b1, R, 1'b1, 32'h00000012, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 5'd9,  1'b1, 1'b1, 3'b100, 2'd2, 32'h0, 1'b1, R, 1'b1, 32'h000000FF, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 5'd10, 1'b1, 1'b1, 3'b001, 2'd0, 32'h0, 1'b1, R, 1'b1, 32'h00001234, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 5'd0,  1'b1, 1'b0, 3'b000, 2'd0, 32'h12345678, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 5'd11, 1'b1, 1'b1, 3'b001, 2'd1, 32'h0, 1'b1, R, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 5'd11, 1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 1'b1, R, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 5'd11, 1'b1, 1'b1, 3'b010, 2'd2, 32'h0, 1'b1, R, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 5'd11, 1'b1, 1'b1, 3'b110, 2'd0, 32'h0, 1'b0, R, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 5'd3,  1'b0, 1'b0, 3'b000, 2'd0, 32'h55AA55AA, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 5'd12, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 1'b1, R, 1'b0, 32'h0, 1'b0, 1'b0};

    // Reset, with a legal stalling load presented to prove the stall is masked
    Reset_n = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_stall", {31'b0, WB_stall}, 32'h0);
    chk("rst_wr_en", {31'b0, Rd_wr_en}, 32'h0);
    chk("rst_fault", {31'b0, Load_fault}, 32'h0);
    chk("rst_addr", {27'b0, Rd_addr}, 32'h0);
    chk("rst_data", Rd_wr_data, 32'h0);
    chk("rst_instret", {28'b0, Instret}, 32'h0);
    @(negedge Clk);
    idle_inputs();
    Reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      drive(vecs[i].valid, vecs[i].rd, vecs[i].wr_en, vecs[i].is_load, vecs[i].f3,
            vecs[i].off, vecs[i].alu, vecs[i].rvalid, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, WB_stall}, 32'h0);
      @(posedge Clk);
      #1;
      if (vecs[i].inc) exp_instret = exp_instret + 1'b1;
      chk($sformatf("v%0d_wr_en", i), {31'b0, Rd_wr_en}, {31'b0, vecs[i].exp_en});
      chk($sformatf("v%0d_fault", i), {31'b0, Load_fault}, {31'b0, vecs[i].exp_fault});
      chk($sformatf("v%0d_instret", i), {28'b0, Instret}, {28'b0, exp_instret});
      if (vecs[i].exp_en) begin
        chk($sformatf("v%0d_addr", i), {27'b0, Rd_addr}, {27'b0, vecs[i].rd});
        chk($sformatf("v%0d_data", i), Rd_wr_data, vecs[i].exp_data);
      end
    end

    // LW rd=7 with data arriving three cycles after acceptance
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      drive(1'b1, 5'd7, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, (c == 3), 32'hCAFEF00D);
      #1;
      chk($sformatf("wait_stall_c%0d", c), {31'b0, WB_stall}, {31'b0, (c < 3)});
      @(posedge Clk);
      #1;
      if (c < 3) chk($sformatf("wait_wr_en_c%0d", c), {31'b0, Rd_wr_en}, 32'h0);
    end
    exp_instret = exp_instret + 1'b1;
    chk("wait_wr_en", {31'b0, Rd_wr_en}, 32'h1);
    chk("wait_addr", {27'b0, Rd_addr}, 32'd7);
    chk("wait_data", Rd_wr_data, 32'hCAFEF00D);
    chk("wait_instret", {28'b0, Instret}, {28'b0, exp_instret});

    // LW with no data ever: 16 stall cycles, then a fault pulse
    for (int c = 0; c < 17; c++) begin
      @(negedge Clk);
      drive(1'b1, 5'd9, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 1'b0, 32'h0);
      #1;
      chk($sformatf("to_stall_c%0d", c), {31'b0, WB_stall}, {31'b0, (c < 16)});
      @(posedge Clk);
      #1;
      if (c < 16) chk($sformatf("to_fault_c%0d", c), {31'b0, Load_fault}, 32'h0);
      chk($sformatf("to_wr_en_c%0d", c), {31'b0, Rd_wr_en}, 32'h0);
    end
    chk("to_fault", {31'b0, Load_fault}, 32'h1);
    chk("to_instret", {28'b0, Instret}, {28'b0, exp_instret});
    @(negedge Clk);
    drive(1'b1, 5'd13, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0BADF00D, 1'b0, 32'h0);
    @(posedge Clk);
    #1;
    exp_instret = exp_instret + 1'b1;
    chk("to_idle_fault", {31'b0, Load_fault}, 32'h0);
    chk("to_idle_wr_en", {31'b0, Rd_wr_en}, 32'h1);
    chk("to_idle_data", Rd_wr_data, 32'h0BADF00D);

    // Reset while a load is pending drops it
    @(negedge Clk);
    drive(1'b1, 5'd14, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rw_accept_stall", {31'b0, WB_stall}, 32'h1);
    @(negedge Clk);
    Reset_n = 1'b0;
    idle_inputs();
    #1;
    chk("rw_stall_in_reset", {31'b0, WB_stall}, 32'h0);
    @(posedge Clk);
    #1;
    exp_instret = '0;
    chk("rw_instret", {28'b0, Instret}, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    Dmem_rvalid = 1'b1;
    Dmem_rdata = 32'h11111111;
    #1;
    chk("rw_stall_after", {31'b0, WB_stall}, 32'h0);
    @(posedge Clk);
    #1;
    chk("rw_wr_en", {31'b0, Rd_wr_en}, 32'h0);
    chk("rw_instret2", {28'b0, Instret}, 32'h0);

    // Counter wraps through 2^CW-1 -> 0
    for (int k = 0; k < 18; k++) begin
      @(negedge Clk);
      drive(1'b1, 5'd1, 1'b1, 1'b0, 3'b000, 2'd0, k, 1'b0, 32'h0);
      @(posedge Clk);
      #1;
      exp_instret = exp_instret + 1'b1;
      chk($sformatf("wrap_k%0d", k), {28'b0, Instret}, {28'b0, exp_instret});
    end
    @(negedge Clk);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
